// File: rtl/stream_capture_fifo.sv
// First-word-fall-through capture FIFO carrying data plus an address sideband.
// Optional parity protection is enabled with `define STREAM_CAPTURE_PARITY_EN.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module stream_capture_fifo #(
  parameter int WIDTH    = `DATA_WIDTH,
  parameter int AW       = `ADDR_WIDTH,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_addr,
  output logic [CW-1:0]    count,
  output logic             almost_full
`ifdef STREAM_CAPTURE_PARITY_EN
  ,
  input  logic             in_par,
  output logic             out_par,
  output logic             par_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PW    = IDX_W + 1;
`ifdef STREAM_CAPTURE_PARITY_EN
  localparam int EW    = WIDTH + AW + 1;
`else
  localparam int EW    = WIDTH + AW;
`endif
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] AF_CNT  = CW'(AF_LEVEL);

  logic [EW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic          out_valid_r, in_ready_r, almost_full_r;
  logic          empty_nxt_s, full_nxt_s;
  logic          push_s, pop_s;
  logic [EW-1:0] wr_entry_s, head_s, hold_r, out_entry_s;

  // in_ready depends only on registered state, so no path from out_ready
  assign push_s = in_valid & in_ready_r;
  assign pop_s  = out_valid_r & out_ready;

  // Next pointer and count values for the current handshakes
  always_comb begin
    wptr_nxt_s  = wptr_r;
    rptr_nxt_s  = rptr_r;
    count_nxt_s = count_r;
    if (push_s) begin
      wptr_nxt_s = wptr_r + PTR_ONE;
    end else begin
      wptr_nxt_s = wptr_r;
    end
    if (pop_s) begin
      rptr_nxt_s = rptr_r + PTR_ONE;
    end else begin
      rptr_nxt_s = rptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Status flags are precomputed from next state and registered with it
  always_comb begin
    empty_nxt_s = 1'b0;
    full_nxt_s  = 1'b0;
    if (wptr_nxt_s == rptr_nxt_s) begin
      empty_nxt_s = 1'b1;
    end else begin
      empty_nxt_s = 1'b0;
    end
    if ((wptr_nxt_s[IDX_W-1:0] == rptr_nxt_s[IDX_W-1:0]) &&
        (wptr_nxt_s[PW-1] != rptr_nxt_s[PW-1])) begin
      full_nxt_s = 1'b1;
    end else begin
      full_nxt_s = 1'b0;
    end
  end

  // Pointer, count and flag registers; flush wins over any handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r        <= {PW{1'b0}};
      rptr_r        <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      out_valid_r   <= 1'b0;
      in_ready_r    <= 1'b1;
      almost_full_r <= 1'b0;
    end else if (flush) begin
      wptr_r        <= {PW{1'b0}};
      rptr_r        <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      out_valid_r   <= 1'b0;
      in_ready_r    <= 1'b1;
      almost_full_r <= 1'b0;
    end else begin
      wptr_r        <= wptr_nxt_s;
      rptr_r        <= rptr_nxt_s;
      count_r       <= count_nxt_s;
      out_valid_r   <= ~empty_nxt_s;
      in_ready_r    <= ~full_nxt_s;
      almost_full_r <= (count_nxt_s >= AF_CNT);
    end
  end

`ifdef STREAM_CAPTURE_PARITY_EN
  logic par_err_r;

  function automatic logic even_par(input logic [WIDTH+AW-1:0] v);
    return ^v;
  endfunction

  assign wr_entry_s = {in_par, in_addr, in_data};

  // Sticky parity error flag, cleared only by reset or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_r <= 1'b0;
    end else if (flush) begin
      par_err_r <= 1'b0;
    end else if (push_s && (in_par != even_par({in_addr, in_data}))) begin
      par_err_r <= 1'b1;
    end else begin
      par_err_r <= par_err_r;
    end
  end

  assign out_par = out_entry_s[EW-1];
  assign par_err = par_err_r;
`else
  assign wr_entry_s = {in_addr, in_data};
`endif

  // Storage array write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wptr_r[IDX_W-1:0]] <= wr_entry_s;
    end
  end

  assign head_s = mem_r[rptr_r[IDX_W-1:0]];

  // Last head value, so the outputs are defined after reset and while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= {EW{1'b0}};
    end else if (out_valid_r) begin
      hold_r <= head_s;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Head entry falls through combinationally when valid
  always_comb begin
    out_entry_s = hold_r;
    if (out_valid_r) begin
      out_entry_s = head_s;
    end else begin
      out_entry_s = hold_r;
    end
  end

  assign out_data    = out_entry_s[WIDTH-1:0];
  assign out_addr    = out_entry_s[WIDTH+AW-1:WIDTH];
  assign out_valid   = out_valid_r;
  assign in_ready    = in_ready_r;
  assign count       = count_r;
  assign almost_full = almost_full_r;

  stream_capture_fifo_chk #(
    .WIDTH (WIDTH),
    .AW    (AW),
    .CW    (CW),
    .PW    (PW)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready_r),
    .in_data  (in_data),
    .in_addr  (in_addr),
    .count    (count_r),
    .wptr     (wptr_r),
    .rptr     (rptr_r)
  );

endmodule

// Simulation-only protocol and consistency properties for the FIFO.
module stream_capture_fifo_chk #(
  parameter int WIDTH = 32,
  parameter int AW    = 32,
  parameter int CW    = 4,
  parameter int PW    = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic             in_valid,
  input logic             in_ready,
  input logic [WIDTH-1:0] in_data,
  input logic [AW-1:0]    in_addr,
  input logic [CW-1:0]    count,
  input logic [PW-1:0]    wptr,
  input logic [PW-1:0]    rptr
);

  logic [PW-1:0] ptr_diff_s;
  assign ptr_diff_s = wptr - rptr;

  a_producer_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && !in_ready) |=> (in_valid && $stable(in_data) && $stable(in_addr)));

  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
    (32'(count) == 32'(ptr_diff_s)));

endmodule

// File: tb/tb_stream_capture_fifo.sv
// Self-checking bench for stream_capture_fifo: vector table plus scoreboard.
// Parity checks are compiled in when STREAM_CAPTURE_PARITY_EN is defined.

module tb_stream_capture_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic [31:0] in_addr = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic [3:0]  count;
  logic        almost_full;
`ifdef STREAM_CAPTURE_PARITY_EN
  logic        in_par = 1'b0;
  logic        out_par;
  logic        par_err;
`endif

  always #5 clk = ~clk;

  stream_capture_fifo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_addr     (in_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .count       (count),
    .almost_full (almost_full)
`ifdef STREAM_CAPTURE_PARITY_EN
    ,
    .in_par      (in_par),
    .out_par     (out_par),
    .par_err     (par_err)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic [31:0] a;
    logic        p;
  } beat_t;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  cnt;
    logic        irdy;
    logic        ovld;
    logic        af;
  } vec_t;

  beat_t       sb[$];
  vec_t        vt[14];
  int          total = 0;
  int          bad = 0;
  int          pops = 0;
  logic        stall_seen = 1'b0;
  logic [63:0] stall_val = 64'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic [31:0] a, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    in_addr   = a;
    out_ready = ordy;
`ifdef STREAM_CAPTURE_PARITY_EN
    in_par    = ^{a, d};
`endif
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    while (out_valid && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_timeout", {63'h0, out_valid}, 64'h0);
    out_ready = 1'b0;
  endtask

  // Scoreboard: record accepted beats, compare pops, check stall stability
  always @(negedge clk) begin
    beat_t exp_b;
    beat_t new_b;
    if (!rst_n) begin
      sb.delete();
      stall_seen = 1'b0;
    end else begin
      if (stall_seen && out_valid) begin
        chk("stall_stable", {out_addr, out_data}, stall_val);
      end
      stall_seen = 1'b0;
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'h1, 64'h0);
        end else begin
          exp_b = sb.pop_front();
          chk("sb_data", {out_addr, out_data}, {exp_b.a, exp_b.d});
`ifdef STREAM_CAPTURE_PARITY_EN
          chk("sb_par", {63'h0, out_par}, {63'h0, exp_b.p});
`endif
        end
        pops++;
      end
      if (out_valid && !out_ready && !flush) begin
        stall_seen = 1'b1;
        stall_val  = {out_addr, out_data};
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        new_b.d = in_data;
        new_b.a = in_addr;
`ifdef STREAM_CAPTURE_PARITY_EN
        new_b.p = in_par;
`else
        new_b.p = 1'b0;
`endif
        sb.push_back(new_b);
      end
      chk("count_le_depth", (count > 4'd8) ? 64'h1 : 64'h0, 64'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   p0;
    int   sent;
    int   guard;
    logic acc;

    // fill / full-with-traffic vectors: iv, data, out_ready, count, in_ready, out_valid, af
    vt[0]  = '{1'b1, 32'h0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 32'h1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 32'h2, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 32'h3, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 32'h4, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 32'h5, 1'b0, 4'd6, 1'b1, 1'b1, 1'b1};
    vt[6]  = '{1'b1, 32'h6, 1'b0, 4'd7, 1'b1, 1'b1, 1'b1};
    vt[7]  = '{1'b1, 32'h7, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1};
    vt[8]  = '{1'b1, 32'h8, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1};
    vt[9]  = '{1'b1, 32'h8, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1};
    vt[10] = '{1'b1, 32'h8, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1};
    vt[11] = '{1'b0, 32'h0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1};
    vt[12] = '{1'b0, 32'h0, 1'b1, 4'd6, 1'b1, 1'b1, 1'b1};
    vt[13] = '{1'b0, 32'h0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0};

    // reset values
    #1 rst_n = 1'b0;
    step();
    step();
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_almost_full", {63'h0, almost_full}, 64'h0);
    chk("rst_count", {60'h0, count}, 64'h0);
    chk("rst_out_word", {out_addr, out_data}, 64'h0);
    rst_n = 1'b1;
    step();

    // single beat, one-cycle latency
    drive(1'b1, 32'hDEADBEEF, 32'h00001000, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("single_valid", {63'h0, out_valid}, 64'h1);
    chk("single_count", {60'h0, count}, 64'h1);
    chk("single_word", {out_addr, out_data}, {32'h00001000, 32'hDEADBEEF});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_pop_count", {60'h0, count}, 64'h0);
    chk("single_pop_valid", {63'h0, out_valid}, 64'h0);

    // fill to full, push/pop while full, partial drain
    p0 = pops;
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].iv, vt[i].d, vt[i].d + 32'h2000, vt[i].ordy);
      step();
      chk($sformatf("vec%0d_count", i), {60'h0, count}, {60'h0, vt[i].cnt});
      chk($sformatf("vec%0d_in_ready", i), {63'h0, in_ready}, {63'h0, vt[i].irdy});
      chk($sformatf("vec%0d_out_valid", i), {63'h0, out_valid}, {63'h0, vt[i].ovld});
      chk($sformatf("vec%0d_almost_full", i), {63'h0, almost_full}, {63'h0, vt[i].af});
    end
    drain(20);
    chk("full_seq_pops", 64'(pops - p0), 64'd9);
    chk("full_seq_sb_empty", 64'(sb.size()), 64'd0);

    // wrap-around with random consumer stalls
    p0 = pops;
    sent = 0;
    guard = 0;
    while (sent < 20 && guard < 400) begin
      drive(1'b1, 32'h100 + 32'(sent), 32'(sent) * 32'd4, 1'($urandom_range(0, 1)));
      acc = in_ready;
      step();
      if (acc) sent++;
      guard++;
    end
    chk("wrap_sent", 64'(sent), 64'd20);
    drain(20);
    chk("wrap_pops", 64'(pops - p0), 64'd20);
    chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

    // flush with a concurrent push
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h500 + 32'(i), 32'h40, 1'b0);
      step();
    end
    chk("pre_flush_count", {60'h0, count}, 64'd5);
    drive(1'b1, 32'h00000BAD, 32'h0BAD, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("flush_count", {60'h0, count}, 64'h0);
    chk("flush_valid", {63'h0, out_valid}, 64'h0);
    chk("flush_in_ready", {63'h0, in_ready}, 64'h1);
    chk("flush_almost_full", {63'h0, almost_full}, 64'h0);
    p0 = pops;
    drive(1'b1, 32'h77, 32'h7700, 1'b0);
    step();
    drain(10);
    chk("post_flush_pops", 64'(pops - p0), 64'd1);

    // asynchronous reset mid-cycle with three entries stored
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h600 + 32'(i), 32'h60, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("pre_rst_count", {60'h0, count}, 64'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_count", {60'h0, count}, 64'h0);
    chk("async_rst_valid", {63'h0, out_valid}, 64'h0);
    chk("async_rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("async_rst_almost_full", {63'h0, almost_full}, 64'h0);
    chk("async_rst_word", {out_addr, out_data}, 64'h0);
    step();
    rst_n = 1'b1;
    step();

`ifdef STREAM_CAPTURE_PARITY_EN
    // wrong parity on the second of four beats
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 32'h3000 + 32'(i), 1'b0);
      if (i == 1) in_par = ~in_par;
      step();
      chk($sformatf("par_err_beat%0d", i), {63'h0, par_err}, (i == 0) ? 64'h0 : 64'h1);
    end
    p0 = pops;
    drain(10);
    chk("par_pops", 64'(pops - p0), 64'd4);
    chk("par_err_sticky", {63'h0, par_err}, 64'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("par_err_flush", {63'h0, par_err}, 64'h0);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
